// File: rtl/text_overlay_pkg.sv
// text_overlay_pkg: constants, width helpers, FSM state type and the glyph
// table used by the text overlay renderer.
package text_overlay_pkg;

  localparam int SPACE_CODE = 'h20;  // blank glyph, used to clear the buffer
  localparam int PIPE_LAT   = 3;     // pixel in -> blank/letra out

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a linear cell address for a cols x rows text window.
  function automatic int cell_addr_w(input int cols, input int rows);
    return idx_w(cols * rows);
  endfunction

  // One 8-pixel glyph row, MSB = leftmost pixel. Codes without an entry
  // (space included) render as all-zero rows.
  function automatic logic [7:0] glyph_row(input int unsigned code,
                                           input int unsigned row);
    logic [7:0] bits;
    bits = 8'h00;
    case (code)
      'h41: begin  // 'A'
        case (row)
          2:                 bits = 8'h10;
          3:                 bits = 8'h38;
          4:                 bits = 8'h6C;
          5, 6:              bits = 8'hC6;
          7:                 bits = 8'hFE;
          8, 9, 10, 11:      bits = 8'hC6;
          default:           bits = 8'h00;
        endcase
      end
      'h7F:    bits = 8'hFF;  // solid block
      default: bits = 8'h00;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/text_overlay_renderer_font_rom.sv
// font_rom: 2^CODE_W * CHAR_H words of CHAR_W bits addressed by
// {code, glyph_row}, with a single registered read port. Contents come from
// the glyph table in text_overlay_pkg.
module font_rom
  import text_overlay_pkg::*;
#(
  parameter int CODE_W = 7,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  localparam int ROW_W = idx_w(CHAR_H)
) (
  input  logic              clk,
  input  logic [CODE_W-1:0] i_code,
  input  logic [ROW_W-1:0]  i_row,
  output logic [CHAR_W-1:0] o_data
);

  logic [CHAR_W-1:0] r_data;

  // Registered lookup of one glyph row; no reset, the value is always
  // overwritten by the next read.
  always_ff @(posedge clk) begin
    r_data <= CHAR_W'(glyph_row(int'(i_code), int'(i_row)));
  end

  assign o_data = r_data;

endmodule

// File: rtl/text_overlay_renderer.sv
// text_overlay_renderer: classifies each pixel from the timing generator as
// blank and/or lit by a glyph from a writable character-cell buffer.
// Three-stage pipeline, one pixel per clock:
//   S1 position decode, S2 char-RAM read, S3 font-ROM read.
// Optional build macro TEXT_CURSOR_BLINK_EN adds a blinking inverted cursor
// cell driven by i_cursor_col / i_cursor_row.
module text_overlay_renderer
  import text_overlay_pkg::*;
#(
  parameter int POS_W    = 11,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16,
  parameter int COLS     = 40,
  parameter int ROWS     = 15,
  parameter int ORIGIN_X = 160,
  parameter int ORIGIN_Y = 120,
  parameter int CODE_W   = 7,
  localparam int COL_W   = idx_w(COLS),
  localparam int ROW_W   = idx_w(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pix_valid,
  input  logic [POS_W-1:0]  i_pos_x,
  input  logic [POS_W-1:0]  i_pos_y,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [COL_W-1:0]  i_wr_col,
  input  logic [ROW_W-1:0]  i_wr_row,
  input  logic [CODE_W-1:0] i_wr_code,
`ifdef TEXT_CURSOR_BLINK_EN
  input  logic [COL_W-1:0]  i_cursor_col,
  input  logic [ROW_W-1:0]  i_cursor_row,
`endif
  output logic              o_out_valid,
  output logic              o_blank,
  output logic              o_letra
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = cell_addr_w(COLS, ROWS);
  localparam int GROW_W = idx_w(CHAR_H);
  localparam int GCOL_W = idx_w(CHAR_W);
  localparam int WIN_W  = COLS * CHAR_W;
  localparam int WIN_H  = ROWS * CHAR_H;

  // ---------------------------------------------------------------- FSM
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;

  // INIT sweeps every cell once, then the buffer is open to writes in RUN.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      r_state   <= INIT;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_clr_cnt == ADDR_W'(CELLS - 1)) begin
            r_state   <= RUN;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= INIT;
      endcase
    end
  end

  // ------------------------------------------------------ S1 decode
  logic [POS_W:0]    w_dx, w_dy;  // one extra bit: negative = left/above window
  logic              w_blank, w_in_win;
  logic [ADDR_W-1:0] w_addr;

  assign w_dx     = {1'b0, i_pos_x} - (POS_W+1)'(ORIGIN_X);
  assign w_dy     = {1'b0, i_pos_y} - (POS_W+1)'(ORIGIN_Y);
  assign w_blank  = (i_pos_x >= POS_W'(H_ACTIVE)) || (i_pos_y >= POS_W'(V_ACTIVE));
  assign w_in_win = !w_dx[POS_W] && (w_dx < (POS_W+1)'(WIN_W)) &&
                    !w_dy[POS_W] && (w_dy < (POS_W+1)'(WIN_H)) && !w_blank;
  assign w_addr   = ADDR_W'(int'(w_dy >> GROW_W) * COLS + int'(w_dx >> GCOL_W));

  logic              r1_valid, r1_blank, r1_in_win, r1_cursor;
  logic [ADDR_W-1:0] r1_addr;
  logic [GROW_W-1:0] r1_grow;
  logic [GCOL_W-1:0] r1_gcol;
  logic              w_cursor_hit;

`ifdef TEXT_CURSOR_BLINK_EN
  logic [4:0] r_frame_cnt;
  logic       r_blink_on;

  // Count frames on the (0,0) pixel; flip the blink phase every 30 frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b0;
    end else if (i_pix_valid && (i_pos_x == '0) && (i_pos_y == '0)) begin
      if (r_frame_cnt == 5'd29) begin
        r_frame_cnt <= '0;
        r_blink_on  <= !r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 5'd1;
      end
    end
  end

  assign w_cursor_hit = r_blink_on && w_in_win &&
                        ((w_dx >> GCOL_W) == (POS_W+1)'(i_cursor_col)) &&
                        ((w_dy >> GROW_W) == (POS_W+1)'(i_cursor_row));
`else
  assign w_cursor_hit = 1'b0;
`endif

  // Stage 1: register pixel class, cell address and glyph coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid  <= 1'b0;
      r1_blank  <= 1'b0;
      r1_in_win <= 1'b0;
      r1_cursor <= 1'b0;
    end else begin
      r1_valid  <= i_pix_valid;
      r1_blank  <= i_pix_valid && w_blank;
      r1_in_win <= i_pix_valid && w_in_win;
      r1_cursor <= i_pix_valid && w_cursor_hit;
    end
    r1_addr <= w_addr;
    r1_grow <= w_dy[GROW_W-1:0];
    r1_gcol <= w_dx[GCOL_W-1:0];
  end

  // -------------------------------------------- char RAM port arbitration
  logic              w_wr_in_range;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_ram_re, w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [CODE_W-1:0] w_ram_wdata;

  assign w_wr_in_range = (int'(i_wr_col) < COLS) && (int'(i_wr_row) < ROWS);
  assign w_wr_addr     = ADDR_W'(int'(i_wr_row) * COLS + int'(i_wr_col));
  // A window pixel in S1 owns the port next edge, so user writes wait.
  assign o_wr_ready    = (r_state == RUN) && !r1_in_win;

  // Single port: clear sweep first, then pixel reads, then user writes.
  // Out-of-range user writes are acknowledged but never reach the RAM.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    w_ram_re    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_waddr = r_clr_cnt;
    w_ram_wdata = CODE_W'(SPACE_CODE);
    if (r_state == INIT) begin
      w_ram_we = 1'b1;
    end else if (r1_in_win) begin
      w_ram_re = 1'b1;
    end else if (i_wr_valid && w_wr_in_range) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = w_wr_addr;
      w_ram_wdata = i_wr_code;
    end
  end

  logic [CODE_W-1:0] r_char_mem [CELLS];
  logic [CODE_W-1:0] r_rd_code;

  // Stage 2 memory: one synchronous read or one write per cycle.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the INIT sweep clears it instead.
    if (w_ram_re) begin
      r_rd_code <= r_char_mem[r1_addr];
    end else if (w_ram_we) begin
      r_char_mem[w_ram_waddr] <= w_ram_wdata;
    end
  end

  // ------------------------------------------------- S2 / S3 sideband
  logic              r2_valid, r2_blank, r2_in_win, r2_cursor, r2_run;
  logic [GROW_W-1:0] r2_grow;
  logic [GCOL_W-1:0] r2_gcol;
  logic              r3_valid, r3_blank, r3_in_win, r3_cursor, r3_run;
  logic [GCOL_W-1:0] r3_gcol;

  // Stage 2: delay sideband alongside the char-RAM read; r2_run marks
  // reads that actually won the port (not overridden by the clear sweep).
  always_ff @(posedge clk) begin
    if (reset) begin
      r2_valid  <= 1'b0;
      r2_blank  <= 1'b0;
      r2_in_win <= 1'b0;
      r2_cursor <= 1'b0;
      r2_run    <= 1'b0;
    end else begin
      r2_valid  <= r1_valid;
      r2_blank  <= r1_blank;
      r2_in_win <= r1_in_win;
      r2_cursor <= r1_cursor;
      r2_run    <= (r_state == RUN);
    end
    r2_grow <= r1_grow;
    r2_gcol <= r1_gcol;
  end

  // Stage 3: delay sideband alongside the font-ROM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r3_valid  <= 1'b0;
      r3_blank  <= 1'b0;
      r3_in_win <= 1'b0;
      r3_cursor <= 1'b0;
      r3_run    <= 1'b0;
    end else begin
      r3_valid  <= r2_valid;
      r3_blank  <= r2_blank;
      r3_in_win <= r2_in_win;
      r3_cursor <= r2_cursor;
      r3_run    <= r2_run;
    end
    r3_gcol <= r2_gcol;
  end

  logic [CHAR_W-1:0] w_font_row;
  logic              w_bit;

  font_rom #(
    .CODE_W (CODE_W),
    .CHAR_W (CHAR_W),
    .CHAR_H (CHAR_H)
  ) u_font_rom (
    .clk    (clk),
    .i_code (r_rd_code),
    .i_row  (r2_grow),
    .o_data (w_font_row)
  );

  // MSB of a glyph row is the leftmost pixel.
  assign w_bit = w_font_row[GCOL_W'(CHAR_W - 1) - r3_gcol];

  assign o_out_valid = r3_valid;
  assign o_blank     = r3_blank;
  assign o_letra     = (w_bit ^ r3_cursor) && r3_in_win && !r3_blank && r3_run;

endmodule

// File: tb/tb_text_overlay_renderer.sv
// Directed bench for text_overlay_renderer: reset/INIT timing, glyph scan,
// blank boundaries, write back-pressure, dropped writes, reset recovery and
// (with TEXT_CURSOR_BLINK_EN) cursor blinking.
module tb_text_overlay_renderer;
  import text_overlay_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [10:0] pos_x, pos_y;
  logic        wr_valid, wr_ready;
  logic [5:0]  wr_col;
  logic [3:0]  wr_row;
  logic [6:0]  wr_code;
  logic        out_valid, blank, letra;
`ifdef TEXT_CURSOR_BLINK_EN
  logic [5:0]  cursor_col;
  logic [3:0]  cursor_row;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Expected rows of glyph 'A' (0x41), MSB = leftmost pixel.
  logic [7:0] a_rows [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                              8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  text_overlay_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .i_pix_valid (pix_valid),
    .i_pos_x     (pos_x),
    .i_pos_y     (pos_y),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_col    (wr_col),
    .i_wr_row    (wr_row),
    .i_wr_code   (wr_code),
`ifdef TEXT_CURSOR_BLINK_EN
    .i_cursor_col(cursor_col),
    .i_cursor_row(cursor_row),
`endif
    .o_out_valid (out_valid),
    .o_blank     (blank),
    .o_letra     (letra)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present one pixel, check outputs PIPE_LAT cycles later.
  task automatic probe(input string tag, input int x, input int y,
                       input logic exp_blank, input logic exp_letra);
    pix_valid = 1'b1;
    pos_x     = 11'(x);
    pos_y     = 11'(y);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (PIPE_LAT - 1) @(negedge clk);
    check($sformatf("%s.valid", tag), out_valid, 1);
    check($sformatf("%s.blank", tag), blank, exp_blank);
    check($sformatf("%s.letra", tag), letra, exp_letra);
  endtask

  // Called at a negedge: hold a write request until accepted (bounded).
  task automatic write_cell(input int col, input int row, input int code);
    int waited;
    waited   = 0;
    wr_valid = 1'b1;
    wr_col   = 6'(col);
    wr_row   = 4'(row);
    wr_code  = 7'(code);
    while (!wr_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("wr_ack(%0d,%0d)", col, row), (waited < 50), 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pos_x     = '0;
      pos_y     = '0;
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r, c;
    logic [2:0] e;

    reset     = 1'b1;
    pix_valid = 1'b0;
    pos_x     = '0;
    pos_y     = '0;
    wr_valid  = 1'b0;
    wr_col    = '0;
    wr_row    = '0;
    wr_code   = '0;
`ifdef TEXT_CURSOR_BLINK_EN
    cursor_col = 6'd1;
    cursor_row = 4'd0;
`endif

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.blank", blank, 0);
    check("rst.letra", letra, 0);
    check("rst.wr_ready", wr_ready, 0);

    // INIT: letra forced low, wr_ready rises after exactly 600 cycles.
    reset = 1'b0;
    probe("init_win", 160, 127, 0, 0);
    repeat (596) @(negedge clk);
    check("init.ready_599", wr_ready, 0);
    @(negedge clk);
    check("init.ready_600", wr_ready, 1);

    // Idle buffer: window pixels unlit.
    probe("idle_a", 160, 120, 0, 0);
    probe("idle_b", 300, 200, 0, 0);
    probe("idle_c", 479, 359, 0, 0);

    // 'A' in cell (0,0), scanned one pixel per clock.
    write_cell(0, 0, 'h41);
    for (int i = 0; i < 128 + PIPE_LAT; i++) begin
      if (i >= PIPE_LAT) begin
        k = i - PIPE_LAT;
        r = k / 8;
        c = k % 8;
        e = {1'b1, 1'b0, a_rows[r][7-c]};
        check($sformatf("scanA r%0d c%0d", r, c), {out_valid, blank, letra}, e);
      end
      if (i < 128) begin
        pix_valid = 1'b1;
        pos_x     = 11'(160 + (i % 8));
        pos_y     = 11'(120 + (i / 8));
      end else begin
        pix_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("scanA.tail_valid", out_valid, 0);

    // Blank boundaries.
    probe("blank_x640", 640, 10, 1, 0);
    probe("blank_y480", 10, 480, 1, 0);
    probe("edge_639_479", 639, 479, 0, 0);

    // Window edges with a solid block in the bottom-right cell.
    write_cell(39, 14, 'h7F);
    probe("blk_in_tl", 472, 344, 0, 1);
    probe("blk_in_br", 479, 359, 0, 1);
    probe("blk_out_x", 480, 359, 0, 0);
    probe("blk_out_y", 479, 360, 0, 0);
    probe("A_lit_r7", 160, 127, 0, 1);
    probe("left_of_win", 159, 127, 0, 0);

    // Write held while window pixels stream: blocked, then accepted.
    pix_valid = 1'b1;
    pos_x     = 11'd160;
    pos_y     = 11'd120;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_col   = 6'd2;
    wr_row   = 4'd0;
    wr_code  = 7'h41;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("busy.ready_%0d", i), wr_ready, 0);
      pos_x = 11'(160 + i);
      @(negedge clk);
    end
    check("busy.ready_last", wr_ready, 0);
    pix_valid = 1'b0;
    @(negedge clk);
    check("busy.ready_free", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    probe("cell2_lit", 179, 122, 0, 1);
    probe("cell2_dark", 178, 122, 0, 0);

    // Out-of-range writes: acknowledged, no cell changes.
    write_cell(40, 0, 'h7F);
    write_cell(0, 15, 'h7F);
    probe("oor_cell39", 472, 120, 0, 0);
    probe("oor_alias", 160, 136, 0, 0);

    // Reset mid-RUN clears outputs next cycle.
    probe("pre_rst", 640, 10, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rstrun.out_valid", out_valid, 0);
    check("rstrun.blank", blank, 0);
    check("rstrun.wr_ready", wr_ready, 0);
    reset = 1'b0;

    // Reset mid-INIT restarts the clear sweep.
    repeat (200) @(negedge clk);
    probe("init_blank", 10, 480, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rstinit.out_valid", out_valid, 0);
    check("rstinit.blank", blank, 0);
    reset = 1'b0;
    repeat (599) @(negedge clk);
    check("reinit.ready_599", wr_ready, 0);
    @(negedge clk);
    check("reinit.ready_600", wr_ready, 1);
    probe("lost_A_r3", 162, 123, 0, 0);
    probe("lost_A_r7", 160, 127, 0, 0);
    probe("lost_cell2", 179, 122, 0, 0);
    probe("lost_block", 479, 359, 0, 0);

`ifdef TEXT_CURSOR_BLINK_EN
    // Cursor at (1,0): dark through 29 frames, inverted after 30, back after 60.
    frame_pulses(29);
    probe("cur_off_29", 170, 125, 0, 0);
    frame_pulses(1);
    probe("cur_on_mid", 170, 125, 0, 1);
    probe("cur_on_tl", 168, 120, 0, 1);
    probe("cur_on_br", 175, 135, 0, 1);
    probe("cur_on_next", 176, 125, 0, 0);
    probe("cur_on_prev", 167, 125, 0, 0);
    frame_pulses(30);
    probe("cur_off_60", 170, 125, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
